// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron epoch scheduler.
// ROM word layout is {x1, x2, t}, with t in the LSB.
package perceptron_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_READY,
    S_FETCH,
    S_DELIVER,
    S_ABORT,
    S_DONE
  } state_t;

  localparam int DEF_N_SAMPLES  = 16;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_MAX_EPOCHS = 64;
  localparam int DEF_EP_W       = 7;

  // Field offsets within a ROM word of the default width.
  localparam int T_BIT  = 0;
  localparam int X2_MSB = DEF_DATA_W;
  localparam int X1_MSB = 2 * DEF_DATA_W;

  // The same offsets for any sample width.
  function automatic int x2_msb(input int data_w);
    return data_w;
  endfunction

  function automatic int x1_msb(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/perceptron_sample_addr_gen.sv
// Sample address register with epoch wrap, last-address and epoch-start compare.
// Define PERCEPTRON_EPOCH_ROTATE_EN to make epoch e start at address (e mod N_SAMPLES).
module perceptron_sample_addr_gen
  import perceptron_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_start,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_start,
  output logic              at_start,
  output logic              at_last
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);

  logic [ADDR_W-1:0] addr_q;

`ifdef PERCEPTRON_EPOCH_ROTATE_EN
  logic [ADDR_W-1:0] start_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      start_q <= '0;
    end else if (load_start) begin
      start_q <= next_start;
    end
  end

  assign next_start = (start_q == LAST) ? '0 : start_q + ADDR_W'(1);
  assign at_start   = (addr_q == start_q);
  // The epoch ends on the address just before its rotated start.
  assign at_last    = (addr_q == ((start_q == '0) ? LAST : start_q - ADDR_W'(1)));
`else
  assign next_start = '0;
  assign at_start   = (addr_q == '0);
  assign at_last    = (addr_q == LAST);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      addr_q <= '0;
    end else if (load_start) begin
      addr_q <= next_start;
    end else if (advance) begin
      addr_q <= (addr_q == LAST) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/perceptron_epoch_scheduler.sv
// Epoch sequencer between the go/done handshake, the sample ROM and the perceptron trainer.
// Optional PERCEPTRON_EPOCH_ROTATE_EN rotates each epoch's start address (see address generator).
module perceptron_epoch_scheduler
  import perceptron_pkg::*;
#(
  parameter int N_SAMPLES  = DEF_N_SAMPLES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_EPOCHS = DEF_MAX_EPOCHS,
  parameter int EP_W       = DEF_EP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic                timeout,
  output logic                trn_start,
  output logic                trn_abort,
  input  logic                trn_rd_req,
  input  logic                trn_err,
  input  logic                trn_done,
  output logic [DATA_W-1:0]   trn_x1,
  output logic [DATA_W-1:0]   trn_x2,
  output logic                trn_t,
  output logic                trn_valid,
  output logic                trn_eof,
  output logic                trn_epoch_err,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [2*DATA_W:0]   rom_data,
  output logic [EP_W-1:0]     epoch_cnt,
  output logic [ADDR_W:0]     err_cnt,
  output logic [ADDR_W:0]     last_err
);

  localparam int X1_HI = x1_msb(DATA_W);
  localparam int X2_HI = x2_msb(DATA_W);
  localparam logic [ADDR_W:0] ERR_MAX   = '1;
  localparam logic [EP_W-1:0] EP_LIMIT  = EP_W'(MAX_EPOCHS);
  localparam logic [EP_W-1:0] EP_LAST   = EP_W'(MAX_EPOCHS - 1);

  state_t state_q, state_d;

  logic              accept_go, serve, close, hit_limit, set_conv, deliver;
  logic              delivered_any;
  logic [EP_W-1:0]   ep_inc;
  logic [ADDR_W:0]   err_inc;
  logic [ADDR_W-1:0] addr, next_start;
  logic              at_start, at_last;

  perceptron_sample_addr_gen #(
    .N_SAMPLES(N_SAMPLES),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept_go),
    .load_start(close),
    .advance   (deliver),
    .addr      (addr),
    .next_start(next_start),
    .at_start  (at_start),
    .at_last   (at_last)
  );

  assign ep_inc  = (epoch_cnt == '1) ? epoch_cnt : epoch_cnt + EP_W'(1);
  assign err_inc = (trn_err && err_cnt != ERR_MAX) ? err_cnt + (ADDR_W+1)'(1) : err_cnt;
  assign deliver = (state_q == S_DELIVER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    accept_go = 1'b0;
    serve     = 1'b0;
    close     = 1'b0;
    hit_limit = 1'b0;
    set_conv  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          accept_go = 1'b1;
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        if (!trn_done) state_d = S_READY;
      end
      S_READY: begin
        if (trn_rd_req) begin
          close = at_start && delivered_any;
          if (close && ep_inc == EP_LIMIT) begin
            hit_limit = 1'b1;
            state_d   = S_ABORT;
          end else begin
            serve   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (trn_done) begin
          set_conv = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_FETCH:   state_d = S_DELIVER;
      S_DELIVER: state_d = S_READY;
      S_ABORT:   state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trn_start     <= 1'b0;
      trn_valid     <= 1'b0;
      trn_x1        <= '0;
      trn_x2        <= '0;
      trn_t         <= 1'b0;
      trn_eof       <= 1'b0;
      rom_addr      <= '0;
      epoch_cnt     <= '0;
      err_cnt       <= '0;
      last_err      <= '0;
      converged     <= 1'b0;
      timeout       <= 1'b0;
      delivered_any <= 1'b0;
    end else begin
      trn_start <= accept_go;
      trn_valid <= deliver;
      if (accept_go) begin
        epoch_cnt     <= '0;
        err_cnt       <= '0;
        last_err      <= '0;
        converged     <= 1'b0;
        timeout       <= 1'b0;
        delivered_any <= 1'b0;
      end else begin
        // An error coincident with the closing request belongs to the closing epoch.
        if (close) begin
          epoch_cnt <= ep_inc;
          last_err  <= err_inc;
          err_cnt   <= '0;
        end else if (busy) begin
          err_cnt <= err_inc;
        end
        if (set_conv)  converged <= 1'b1;
        if (hit_limit) timeout   <= 1'b1;
      end
      if (serve) begin
        rom_addr <= close ? next_start : addr;
      end
      if (deliver) begin
        trn_x1        <= rom_data[X1_HI -: DATA_W];
        trn_x2        <= rom_data[X2_HI -: DATA_W];
        trn_t         <= rom_data[T_BIT];
        trn_eof       <= at_last;
        delivered_any <= 1'b1;
      end
    end
  end

  assign busy          = !(state_q inside {S_IDLE, S_DONE});
  assign done          = !busy;
  assign trn_abort     = (state_q == S_ABORT);
  assign trn_epoch_err = (err_cnt != '0) && (epoch_cnt < EP_LAST);

endmodule

// File: tb/tb_perceptron_epoch_scheduler.sv
// Self-checking bench: directed epoch scenarios plus randomized runs against an epoch-level model.
// Honours PERCEPTRON_EPOCH_ROTATE_EN when the design is built with it.
module tb_perceptron_epoch_scheduler;

  localparam int N      = 4;
  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int MAXE   = 3;
  localparam int EW     = 3;
  localparam int ERRMAX = 15;
`ifdef PERCEPTRON_EPOCH_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, go, trn_rd_req, trn_err, trn_done;
  logic          busy, done, converged, timeout, trn_start, trn_abort;
  logic [DW-1:0] trn_x1, trn_x2;
  logic          trn_t, trn_valid, trn_eof, trn_epoch_err;
  logic [AW-1:0] rom_addr;
  logic [2*DW:0] rom_data;
  logic [EW-1:0] epoch_cnt;
  logic [AW:0]   err_cnt, last_err;

  logic [2*DW:0] rom_mem [2**AW];

  int checks = 0;
  int errors = 0;

  // Epoch-level reference state
  int m_epoch, m_errs, m_last, m_pos;
  bit m_any;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  perceptron_epoch_scheduler #(
    .N_SAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .MAX_EPOCHS(MAXE), .EP_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
    .converged(converged), .timeout(timeout), .trn_start(trn_start),
    .trn_abort(trn_abort), .trn_rd_req(trn_rd_req), .trn_err(trn_err),
    .trn_done(trn_done), .trn_x1(trn_x1), .trn_x2(trn_x2), .trn_t(trn_t),
    .trn_valid(trn_valid), .trn_eof(trn_eof), .trn_epoch_err(trn_epoch_err),
    .rom_addr(rom_addr), .rom_data(rom_data), .epoch_cnt(epoch_cnt),
    .err_cnt(err_cnt), .last_err(last_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > ERRMAX) ? ERRMAX : v;
  endfunction

  function automatic int start_of(input int e);
    return ROT ? (e % N) : 0;
  endfunction

  task automatic start_run(input bit drop_done);
    m_epoch = 0; m_errs = 0; m_last = 0; m_pos = 0; m_any = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("start_pulse", trn_start, 1);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_conv_clr", converged, 0);
    check("start_tmo_clr", timeout, 0);
    check("start_epoch_clr", epoch_cnt, 0);
    check("start_err_clr", err_cnt, 0);
    if (drop_done) begin
      trn_done = 1'b0;
      tick();
      check("start_pulse_end", trn_start, 0);
    end
  endtask

  // One trainer read request; returns 1 when the scheduler aborts instead of serving it.
  task automatic do_request(input bit err_on_req, input bit err_upd, output bit aborted);
    bit            hit;
    int            a;
    logic [2*DW:0] w;
    aborted = 1'b0;
    hit     = 1'b0;
    if (m_any && m_pos == 0) begin
      m_last  = sat(m_errs + int'(err_on_req));
      m_epoch = m_epoch + 1;
      m_errs  = 0;
      hit     = (m_epoch == MAXE);
    end else if (err_on_req) begin
      m_errs = sat(m_errs + 1);
    end
    trn_rd_req = 1'b1;
    trn_err    = err_on_req;
    tick();
    trn_rd_req = 1'b0;
    trn_err    = 1'b0;
    check("req_epoch_cnt", epoch_cnt, m_epoch);
    check("req_last_err", last_err, m_last);
    check("req_err_cnt", err_cnt, m_errs);
    if (hit) begin
      check("abort_pulse", trn_abort, 1);
      check("abort_timeout", timeout, 1);
      check("abort_no_valid", trn_valid, 0);
      tick();
      check("abort_single", trn_abort, 0);
      check("abort_done", done, 1);
      check("abort_no_valid2", trn_valid, 0);
      aborted = 1'b1;
      return;
    end
    a = (start_of(m_epoch) + m_pos) % N;
    w = rom_mem[a];
    check("rom_addr", rom_addr, a);
    check("lat_valid0", trn_valid, 0);
    tick();
    check("lat_valid1", trn_valid, 0);
    tick();
    check("dlv_valid", trn_valid, 1);
    check("dlv_x1", trn_x1, w[2*DW -: DW]);
    check("dlv_x2", trn_x2, w[DW -: DW]);
    check("dlv_t", trn_t, w[0]);
    check("dlv_eof", trn_eof, (m_pos == N-1));
    check("dlv_epoch_err", trn_epoch_err, (m_errs != 0 && m_epoch < MAXE-1));
    m_pos = (m_pos + 1) % N;
    m_any = 1'b1;
    trn_err = err_upd;
    tick();
    trn_err = 1'b0;
    if (err_upd) m_errs = sat(m_errs + 1);
    check("upd_valid_drop", trn_valid, 0);
    check("upd_err_cnt", err_cnt, m_errs);
    check("upd_eof_hold", trn_eof, (m_pos == 0));
  endtask

  task automatic finish_run();
    trn_done = 1'b1;
    tick();
    check("fin_converged", converged, 1);
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    check("fin_timeout", timeout, 0);
    check("fin_epoch_cnt", epoch_cnt, m_epoch);
  endtask

  initial begin
    bit ab;
    int nsamp;
    rst = 1'b1; go = 1'b0; trn_rd_req = 1'b0; trn_err = 1'b0; trn_done = 1'b1;
    for (int i = 0; i < 2**AW; i++) rom_mem[i] = (2*DW+1)'($urandom);
    repeat (2) tick();
    check("rst_done", done, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", trn_valid, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_x1", trn_x1, 0);
    check("rst_epoch", epoch_cnt, 0);
    check("rst_last_err", last_err, 0);
    check("rst_flags", {converged, timeout, trn_start, trn_abort, trn_eof, trn_epoch_err}, 0);
    rst = 1'b0;
    tick();

    // One clean epoch, trainer converges
    start_run(1'b1);
    for (int i = 0; i < N; i++) do_request(1'b0, 1'b0, ab);
    finish_run();

    // Errors across epochs until the limit; includes coincident error at close
    start_run(1'b1);
    do_request(1'b0, 1'b0, ab);
    do_request(1'b0, 1'b1, ab);
    do_request(1'b0, 1'b1, ab);
    do_request(1'b0, 1'b0, ab);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_ignored_start", trn_start, 0);
    check("go_ignored_busy", busy, 1);
    do_request(1'b0, 1'b1, ab);
    check("close_last_err", last_err, 2);
    check("close_epoch", epoch_cnt, 1);
    for (int i = 0; i < N-1; i++) do_request(1'b0, 1'b0, ab);
    do_request(1'b1, 1'b1, ab);
    check("coinc_last_err", last_err, 2);
    for (int i = 0; i < N-1; i++) do_request(1'b0, 1'b0, ab);
    do_request(1'b0, 1'b0, ab);
    check("limit_aborted", ab, 1);
    check("limit_epoch", epoch_cnt, MAXE);
    trn_done = 1'b1;
    tick();

    // Error counter saturation while waiting in ARM
    start_run(1'b0);
    trn_err = 1'b1;
    repeat (20) tick();
    trn_err = 1'b0;
    check("sat_err_cnt", err_cnt, ERRMAX);
    check("sat_epoch_err", trn_epoch_err, 1);
    trn_done = 1'b0;
    tick();
    finish_run();

    // Randomized runs
    for (int run = 0; run < 8; run++) begin
      start_run(1'b1);
      nsamp = $urandom_range(1, 14);
      ab = 1'b0;
      for (int s = 0; s < nsamp && !ab; s++) begin
        repeat ($urandom_range(0, 2)) tick();
        do_request(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ab);
      end
      if (ab) begin
        check("rnd_timeout", timeout, 1);
        trn_done = 1'b1;
        tick();
      end else begin
        finish_run();
      end
    end

    // Reset while a fetch is in flight
    start_run(1'b1);
    do_request(1'b0, 1'b0, ab);
    trn_rd_req = 1'b1;
    tick();
    trn_rd_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_done", done, 1);
    check("mrst_busy", busy, 0);
    check("mrst_rom_addr", rom_addr, 0);
    check("mrst_x", {trn_x1, trn_x2, trn_t}, 0);
    check("mrst_valid", trn_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_no_valid", trn_valid, 0);
      check("mrst_no_abort", trn_abort, 0);
    end
    trn_done = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
